// File: rtl/rx_descrambler_pkg.sv
// Shared 802.11a scrambler definitions: receive FSM states, LFSR taps and widths.
// Used by both the receive descrambler and the transmit scrambler.
package rx_descrambler_pkg;
    localparam int SCR_W            = 7;
    localparam int TAP_HI           = 6;
    localparam int TAP_LO           = 3;
    localparam int SERVICE_BITS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SVC,
        ST_DATA,
        ST_DONE
    } rx_state_e;

    typedef enum logic [1:0] {
        LFSR_HOLD,
        LFSR_LOAD,
        LFSR_STEP
    } lfsr_mode_e;

    // x^7 + x^4 + 1 feedback
    function automatic logic scr_fb(input logic [SCR_W-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction
endpackage

// File: rtl/rx_lfsr7.sv
// 7-bit scrambler LFSR with hold / direct-load / descramble-step modes.
// desc_o is combinational from the current state and bit_i.
module rx_lfsr7
    import rx_descrambler_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mode_i,
    input  logic             bit_i,
    output logic [SCR_W-1:0] s_o,
    output logic             desc_o
);
    logic [SCR_W-1:0] s_q, s_d;
    logic             fb;

    assign fb     = scr_fb(s_q);
    assign desc_o = bit_i ^ fb;
    assign s_o    = s_q;

    always_comb begin
        s_d = s_q;
        case (mode_i)
            LFSR_LOAD: s_d = {s_q[SCR_W-2:0], bit_i};
            LFSR_STEP: s_d = {s_q[SCR_W-2:0], fb};
            default:   s_d = s_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end
endmodule

// File: rtl/rx_descrambler.sv
// 802.11a receive descrambler: recovers seed from SERVICE, strips SERVICE, emits LENGTH*8 PSDU bits.
// OutBit latency 1 per accepted bit; InValid gaps stall everything; Start restarts at any time.
module rx_descrambler
    import rx_descrambler_pkg::*;
#(
    parameter int LEN_W         = 12,
    parameter int SERVICE_BITS  = SERVICE_BITS_DEF,
    parameter bit CHECK_SERVICE = 1'b1
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    output logic             out_valid_o,
    output logic             out_bit_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             service_err_o,
    output logic [SCR_W-1:0] seed_o
);
    localparam int CNT_W = LEN_W + 3;
    localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(SCR_W - 1);
    localparam logic [CNT_W-1:0] SVC_LAST  = CNT_W'(SERVICE_BITS - SCR_W - 1);

    rx_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, data_last;
    lfsr_mode_e       lfsr_mode;
    logic [SCR_W-1:0] lfsr_s;
    logic             desc;
    logic             acc_data;
    logic             out_valid_q, out_bit_q, done_q, serr_q;
    logic [SCR_W-1:0] seed_q;

    assign data_last = {len_q, 3'b000} - CNT_W'(1);
    assign acc_data  = in_valid_i && !start_i && (state_q == ST_DATA);

    rx_lfsr7 u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .mode_i (lfsr_mode),
        .bit_i  (in_bit_i),
        .s_o    (lfsr_s),
        .desc_o (desc)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lfsr_mode = LFSR_HOLD;
        if (start_i) begin
            state_d = ST_SEED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SEED: if (in_valid_i) begin
                    lfsr_mode = LFSR_LOAD;
                    if (cnt_q == SEED_LAST) begin
                        state_d = ST_SVC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SVC: if (in_valid_i) begin
                    lfsr_mode = LFSR_STEP;
                    if (cnt_q == SVC_LAST) begin
                        state_d = (len_q == '0) ? ST_DONE : ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: if (in_valid_i) begin
                    lfsr_mode = LFSR_STEP;
                    if (cnt_q == data_last) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Done is registered off the DONE state so it lands one cycle after the last OutValid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            done_q      <= 1'b0;
            serr_q      <= 1'b0;
            seed_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= (state_q == ST_DONE);
            out_valid_q <= acc_data;
            if (acc_data) begin
                out_bit_q <= desc;
            end
            if (start_i) begin
                len_q  <= length_i;
                serr_q <= 1'b0;
                seed_q <= '0;
            end else begin
                if (in_valid_i && state_q == ST_SEED && cnt_q == SEED_LAST) begin
                    seed_q <= {lfsr_s[SCR_W-2:0], in_bit_i};
                end
                if (CHECK_SERVICE && in_valid_i && state_q == ST_SVC && desc) begin
                    serr_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_bit_o     = out_bit_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign service_err_o = serr_q;
    assign seed_o        = seed_q;
endmodule

// File: tb/tb_rx_descrambler.sv
// Directed bench for rx_descrambler: bit-index frame model checked every cycle plus literal expectations.
module tb_rx_descrambler;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_bit;
    logic [11:0] length;
    logic        out_valid, out_bit, busy, done, service_err;
    logic [6:0]  seed;

    always #5 clk = ~clk;

    rx_descrambler dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .length_i      (length),
        .in_valid_i    (in_valid),
        .in_bit_i      (in_bit),
        .out_valid_o   (out_valid),
        .out_bit_o     (out_bit),
        .busy_o        (busy),
        .done_o        (done),
        .service_err_o (service_err),
        .seed_o        (seed)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Frame model: p[] is the receiver's view of the scrambler sequence, indexed by accepted bit
    bit         p [0:32775];
    int         m_idx, m_len;
    bit         m_active = 1'b0, m_pend = 1'b0;
    logic       e_vld = 1'b0, e_bit = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_serr = 1'b0;
    logic [6:0] e_seed = '0;
    bit         d;

    always @(posedge clk) begin
        e_vld  = 1'b0;
        e_done = m_pend;
        m_pend = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            e_done = 1'b0; e_bit = 1'b0; e_serr = 1'b0; e_seed = '0;
        end else if (start) begin
            m_active = 1'b1; m_len = int'(length); m_idx = 0;
            e_serr = 1'b0; e_seed = '0;
        end else if (m_active && in_valid) begin
            if (m_idx < 7) p[m_idx] = in_bit;
            else           p[m_idx] = p[m_idx-7] ^ p[m_idx-4];
            d = in_bit ^ ((m_idx < 7) ? 1'b0 : p[m_idx]);
            if (m_idx == 6)
                for (int j = 0; j < 7; j++) e_seed[6-j] = p[j];
            if (m_idx >= 7 && m_idx < 16 && d) e_serr = 1'b1;
            if (m_idx >= 16) begin e_vld = 1'b1; e_bit = d; end
            m_idx++;
            if (m_idx == 16 + 8 * m_len) begin m_active = 1'b0; m_pend = 1'b1; end
        end
        e_busy = m_active || m_pend;
    end

    int vld_cnt, done_cnt;
    bit out_q [$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(e_vld));
            if (e_vld) chk("out_bit", 32'(out_bit), 32'(e_bit));
            chk("done", 32'(done), 32'(e_done));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("service_err", 32'(service_err), 32'(e_serr));
            chk("seed", 32'(seed), 32'(e_seed));
            if (out_valid) begin vld_cnt++; out_q.push_back(out_bit); end
            if (done) done_cnt++;
        end
    end

    bit pay [0:15];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        vld_cnt = 0; done_cnt = 0; out_q.delete();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Transmit-side scrambler; the Start cycle carries a junk valid bit that must not be consumed
    task automatic send_frame(input int len, input logic [6:0] sd, input int flip,
                              input bit gaps, input int nbits, output logic [23:0] head);
        logic [6:0] s;
        logic       f, b;
        s = sd;
        head = '0;
        tick();
        start = 1'b1; length = 12'(len); in_valid = 1'b1; in_bit = 1'b1;
        tick();
        start = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            if (gaps && (k % 2 == 1)) begin
                in_valid = 1'b0; in_bit = 1'($urandom); tick();
            end
            f = s[6] ^ s[3];
            s = {s[5:0], f};
            b = f ^ ((k >= 16 && k < 32) ? pay[k-16] : 1'b0);
            if (k == flip) b = ~b;
            if (k < 24) head[23-k] = b;
            in_valid = 1'b1; in_bit = b;
            tick();
        end
        in_valid = 1'b0;
    endtask

    function automatic int ones_in_q();
        int n = 0;
        foreach (out_q[i]) n += int'(out_q[i]);
        return n;
    endfunction

    logic [23:0] head;
    logic [23:0] exp_head;
    logic [6:0]  rseed;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0; length = '0;
        for (int i = 0; i < 16; i++) pay[i] = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_seed", 32'(seed), 32'd0);
        rst = 1'b0;

        // 1: zero frame, TX seed all ones, with ignored tail bits
        clear_stats();
        send_frame(1, 7'h7f, -1, 1'b0, 24, head);
        exp_head = 24'b000011101111001011001001;
        chk("t1_stimulus", 32'(head), 32'(exp_head));
        in_valid = 1'b1; in_bit = 1'b1;
        repeat (3) tick();
        idle(4);
        chk("t1_seed", 32'(seed), 32'b0000111);
        chk("t1_vld_cnt", 32'(vld_cnt), 32'd8);
        chk("t1_ones", 32'(ones_in_q()), 32'd0);
        chk("t1_serr", 32'(service_err), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // 2: SERVICE bit 9 corrupted
        clear_stats();
        send_frame(1, 7'h7f, 9, 1'b0, 24, head);
        idle(4);
        chk("t2_serr", 32'(service_err), 32'd1);
        chk("t2_vld_cnt", 32'(vld_cnt), 32'd8);
        chk("t2_ones", 32'(ones_in_q()), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);

        // 3: zero-length PSDU
        clear_stats();
        send_frame(0, 7'h55, -1, 1'b0, 16, head);
        chk("t3_done_early", 32'(done), 32'd0);
        tick();
        chk("t3_done_timing", 32'(done), 32'd1);
        idle(3);
        chk("t3_vld_cnt", 32'(vld_cnt), 32'd0);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // 4: random payload, random seed, InValid toggling
        clear_stats();
        for (int i = 0; i < 16; i++) pay[i] = 1'($urandom);
        rseed = 7'($urandom_range(1, 127));
        send_frame(2, rseed, -1, 1'b1, 32, head);
        idle(4);
        chk("t4_vld_cnt", 32'(vld_cnt), 32'd16);
        for (int i = 0; i < 16 && i < out_q.size(); i++)
            chk("t4_payload", 32'(out_q[i]), 32'(pay[i]));
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);

        // 5: restart after 5 DATA bits, then reset mid-SVC
        clear_stats();
        send_frame(2, 7'h33, -1, 1'b0, 21, head);
        for (int i = 0; i < 16; i++) pay[i] = 1'b0;
        send_frame(1, 7'h7f, -1, 1'b0, 24, head);
        idle(4);
        chk("t5_vld_cnt", 32'(vld_cnt), 32'd13);
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_seed", 32'(seed), 32'b0000111);
        send_frame(1, 7'h7f, 8, 1'b0, 10, head);
        chk("t5_serr_before_rst", 32'(service_err), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rst_outs", 32'({out_valid, out_bit, busy, done, service_err, seed}), 32'd0);
        rst = 1'b0;
        idle(2);

        // 6: maximum length frame
        clear_stats();
        send_frame(4095, 7'h7f, -1, 1'b0, 16 + 32760, head);
        idle(4);
        chk("t6_vld_cnt", 32'(vld_cnt), 32'd32760);
        chk("t6_done_cnt", 32'(done_cnt), 32'd1);
        chk("t6_ones", 32'(ones_in_q()), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
